// File: rtl/df_pkg.sv
// Shared definitions for the parametrised moving-sum FIR:
// output mode encodings and a sign-extension helper.
package df_pkg;

    localparam logic [1:0] MODE_SUM    = 2'b00;
    localparam logic [1:0] MODE_AVG    = 2'b01;
    localparam logic [1:0] MODE_DIFF   = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    // Replicates bit msb of v into every higher bit; callers truncate to OUT_W.
    function automatic logic [31:0] sext(input logic [31:0] v,
                                         input logic [4:0]  msb);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < 32; i++) begin
            if (5'(i) > msb) r[i] = v[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/df_delay_line.sv
// Sample history shift register for the FIR window.
// Tap 0 is the most recent accepted sample (h[1]).
module df_delay_line
    import df_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    shift,
    input  logic [DATA_W-1:0]       din,
    output logic [DEPTH*DATA_W-1:0] taps
);

    logic [DATA_W-1:0] h [DEPTH];

    // A clear with a shift loads din into an otherwise zeroed history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) h[k] <= '0;
        end else if (shift) begin
            h[0] <= din;
            for (int k = 1; k < DEPTH; k++) h[k] <= clr ? '0 : h[k-1];
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) h[k] <= '0;
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) taps[k*DATA_W +: DATA_W] = h[k];
    end

endmodule

// File: rtl/df_fir_param.sv
// N-tap moving-sum FIR with SUM / AVG / DIFF / BYPASS output modes,
// one registered result per accepted sample.
module df_fir_param
    import df_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TAPS     = 4,
    parameter int TAP_LOG2 = $clog2(TAPS),
    parameter int OUT_W    = DATA_W + TAP_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    output logic              primed
);

    localparam int         DEPTH = TAPS - 1;
    localparam int         CNT_W = $clog2(TAPS + 1);
    localparam logic [4:0] DMSB  = 5'(DATA_W - 1);

    logic [DEPTH*DATA_W-1:0] taps;
    logic [DEPTH*DATA_W-1:0] hist;
    logic [OUT_W-1:0]        sum;
    logic [DATA_W:0]         diff;
    logic [OUT_W-1:0]        res;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;

    function automatic logic [OUT_W-1:0] ext(input logic [DATA_W-1:0] v);
        return OUT_W'(sext(32'(v), DMSB));
    endfunction

    df_delay_line #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dl (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .shift (in_valid),
        .din   (in_data),
        .taps  (taps)
    );

    // A same-cycle clear makes the sample see an all-zero history.
    always_comb begin
        hist = clr ? '0 : taps;
        sum  = ext(in_data);
        for (int k = 0; k < DEPTH; k++) begin
            sum = sum + ext(hist[k*DATA_W +: DATA_W]);
        end
        diff = {in_data[DATA_W-1], in_data}
             - {hist[DATA_W-1], hist[DATA_W-1:0]};
        res  = '0;
        unique case (mode)
            MODE_SUM:    res = sum;
            MODE_AVG:    res = OUT_W'($signed(sum) >>> TAP_LOG2);
            MODE_DIFF:   res = OUT_W'(sext(32'(diff), 5'(DATA_W)));
            MODE_BYPASS: res = ext(in_data);
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = in_valid ? CNT_W'(1) : '0;
        end else if (in_valid && cnt != CNT_W'(TAPS)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            cnt       <= cnt_nxt;
            primed    <= (cnt_nxt == CNT_W'(TAPS));
            out_valid <= in_valid;
            if (in_valid) out_data <= res;
        end
    end

endmodule

// File: tb/tb_df_fir_param.sv
// Scoreboard bench for df_fir_param (DATA_W=8, TAPS=4, OUT_W=10)
// using directed vectors with hand-computed results.
module tb_df_fir_param;

    typedef struct {
        logic [9:0] d;
        logic       p;
    } exp_t;

    localparam logic [1:0] SUM = 2'b00;
    localparam logic [1:0] AVG = 2'b01;
    localparam logic [1:0] DIF = 2'b10;
    localparam logic [1:0] BYP = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] mode;
    logic       out_valid;
    logic [9:0] out_data;
    logic       primed;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   run = 0;
    int   max_run = 0;

    df_fir_param dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] d10(input int e);
        logic [9:0] t;
        t = 10'(e);
        return 32'(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("primed", 32'(primed), 32'(e.p));
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic send(input int d, input logic [1:0] m, input logic c,
                        input int e, input logic p);
        exp_t x;
        in_data  = 8'(d);
        mode     = m;
        clr      = c;
        in_valid = 1'b1;
        x.d = 10'(e);
        x.p = p;
        sb.push_back(x);
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        clr      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_only(input int held);
        in_valid = 1'b0;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_out_valid", 32'(out_valid), 32'(0));
        chk("clr_primed", 32'(primed), 32'(0));
        chk("clr_held", 32'(out_data), d10(held));
    endtask

    int stream [7] = '{0, 23, 247, 185, 86, 255, 149};
    int e_sum  [7] = '{0, 23, 14, -57, 29, 5, -93};
    int e_avg  [7] = '{0, 5, 3, -15, 7, 1, -24};
    int e_dif  [7] = '{0, 23, -32, -62, 157, -87, -106};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; mode = SUM;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_primed", 32'(primed), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 7; i++) send(stream[i], SUM, 1'b0, e_sum[i], i >= 3);
        idle();
        clear_only(-93);

        for (int i = 0; i < 7; i++) send(stream[i], AVG, 1'b0, e_avg[i], i >= 3);
        idle();
        clear_only(-24);

        for (int i = 0; i < 7; i++) send(stream[i], DIF, 1'b0, e_dif[i], i >= 3);
        send(128, BYP, 1'b0, -128, 1'b1);
        idle();
        clear_only(-128);

        max_run = 0;
        send(127, SUM, 1'b0, 127, 1'b0);
        send(127, SUM, 1'b0, 254, 1'b0);
        send(127, SUM, 1'b0, 381, 1'b0);
        send(127, SUM, 1'b0, 508, 1'b1);
        send(128, SUM, 1'b0, 253, 1'b1);
        send(128, SUM, 1'b0, -2, 1'b1);
        send(128, SUM, 1'b0, -257, 1'b1);
        send(128, SUM, 1'b0, -512, 1'b1);
        idle();
        chk("back_to_back_run", 32'(max_run), 32'(8));
        chk("gap_out_valid", 32'(out_valid), 32'(0));
        chk("gap_held", 32'(out_data), d10(-512));
        send(0, SUM, 1'b0, -384, 1'b1);
        idle();
        chk("gap2_out_valid", 32'(out_valid), 32'(0));
        chk("gap2_held", 32'(out_data), d10(-384));
        send(0, SUM, 1'b0, -256, 1'b1);
        idle();
        clear_only(-256);

        send(10, SUM, 1'b0, 10, 1'b0);
        send(20, SUM, 1'b0, 30, 1'b0);
        send(30, SUM, 1'b0, 60, 1'b0);
        send(5, SUM, 1'b1, 5, 1'b0);
        send(8, DIF, 1'b0, 3, 1'b0);
        send(7, SUM, 1'b0, 20, 1'b0);
        idle();

        rst = 1'b1; in_valid = 1'b1; in_data = 8'd99; mode = SUM;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'(0));
        chk("midrst_out_data", 32'(out_data), 32'(0));
        chk("midrst_primed", 32'(primed), 32'(0));
        send(40, SUM, 1'b0, 40, 1'b0);
        idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
